// File: rtl/game_pkg.sv
// Shared state encoding and default timing constants for the round sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    TITLE  = 3'd0,
    REVIVE = 3'd1,
    PLAY   = 3'd2,
    DYING  = 3'd3,
    WIN    = 3'd4
  } game_state_enum;

  localparam int DEF_DEATH_FRAMES   = 60;
  localparam int DEF_DEATH_W        = 8;
  localparam int DEF_FRAMES_PER_SEC = 60;
  localparam int DEF_TIME_LIMIT     = 300;

endpackage

// File: rtl/frame_tick_gen.sv
// Rising-edge detector for the frame clock: one Clk-wide tick per frame_clk rise,
// registered so downstream logic sees a clean single-cycle pulse.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic frame_clk_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_clk_q <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      frame_clk_q <= frame_clk;
      frame_tick  <= frame_clk & ~frame_clk_q;
    end
  end

endmodule

// File: rtl/game_flow_controller.sv
// Round sequencer for FireBoy/IceGirl: revive/freeze control, death counting, level completion.
// Define LEVEL_TIMER_EN to build the play-time counter and its time-limit kill.
module game_flow_controller
  import game_pkg::*;
#(
  parameter int DEATH_FRAMES = DEF_DEATH_FRAMES,
  parameter int DEATH_W      = DEF_DEATH_W
`ifdef LEVEL_TIMER_EN
  ,
  parameter int FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
  parameter int TIME_LIMIT     = DEF_TIME_LIMIT
`endif
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic               start_key,
  input  logic               fireboy_hazard,
  input  logic               icegirl_hazard,
  input  logic               fireboy_at_door,
  input  logic               icegirl_at_door,
  output logic               revive,
  output logic               freeze,
  output logic [2:0]         game_state,
  output logic [DEATH_W-1:0] death_count,
  output logic [9:0]         play_seconds
);

  localparam logic [6:0]         FRAME_LAST = 7'(DEATH_FRAMES - 1);
  localparam logic [DEATH_W-1:0] DEATH_MAX  = '1;

  game_state_enum     state_reg, state_next;
  logic [6:0]         frame_cnt_reg, frame_cnt_next;
  logic [DEATH_W-1:0] death_count_reg, death_count_next;
  logic               start_key_q;
  logic               frame_tick;
  logic               start_press;
  logic               hazard;
  logic               timeout;

  frame_tick_gen u_frame_tick (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  always_ff @(posedge Clk) begin
    if (Reset) start_key_q <= 1'b0;
    else       start_key_q <= start_key;
  end

  assign start_press = start_key & ~start_key_q;
  assign hazard      = fireboy_hazard | icegirl_hazard | timeout;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg       <= TITLE;
      frame_cnt_reg   <= '0;
      death_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      frame_cnt_reg   <= frame_cnt_next;
      death_count_reg <= death_count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    frame_cnt_next   = frame_cnt_reg;
    death_count_next = death_count_reg;
    case (state_reg)
      TITLE, WIN: begin
        if (start_press) begin
          state_next       = REVIVE;
          death_count_next = '0;
        end
      end
      REVIVE: begin
        state_next     = PLAY;
        frame_cnt_next = '0;
      end
      PLAY: begin
        // A hazard outranks reaching both doors in the same cycle.
        if (hazard) begin
          state_next = DYING;
          if (death_count_reg != DEATH_MAX) death_count_next = death_count_reg + 1'b1;
        end else if (fireboy_at_door & icegirl_at_door) begin
          state_next = WIN;
        end
      end
      DYING: begin
        if (frame_tick) begin
          if (frame_cnt_reg == FRAME_LAST) begin
            state_next     = REVIVE;
            frame_cnt_next = '0;
          end else begin
            frame_cnt_next = frame_cnt_reg + 7'd1;
          end
        end
      end
      default: state_next = TITLE;
    endcase
  end

  always_comb begin
    revive = 1'b0;
    freeze = 1'b1;
    case (state_reg)
      TITLE, REVIVE: revive = 1'b1;
      PLAY:          freeze = 1'b0;
      default:       ;
    endcase
  end

  assign game_state  = state_reg;
  assign death_count = death_count_reg;

`ifdef LEVEL_TIMER_EN
  localparam logic [5:0] SUB_LAST  = 6'(FRAMES_PER_SEC - 1);
  localparam logic [9:0] SEC_LIMIT = 10'(TIME_LIMIT);

  logic [5:0] sub_cnt_reg;
  logic [9:0] seconds_reg;

  // Time only accumulates while playing; it is frozen in DYING/WIN so it can be shown.
  always_ff @(posedge Clk) begin
    if (Reset || state_reg == REVIVE) begin
      sub_cnt_reg <= '0;
      seconds_reg <= '0;
    end else if (state_reg == PLAY && frame_tick) begin
      if (sub_cnt_reg == SUB_LAST) begin
        sub_cnt_reg <= '0;
        seconds_reg <= seconds_reg + 10'd1;
      end else begin
        sub_cnt_reg <= sub_cnt_reg + 6'd1;
      end
    end
  end

  assign timeout      = (seconds_reg == SEC_LIMIT);
  assign play_seconds = seconds_reg;
`else
  assign timeout      = 1'b0;
  assign play_seconds = '0;
`endif

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed vector table, corner-case sequences and
// randomized stimulus checked against a rule-level model of the round flow.
`timescale 1ns/1ps
module tb_game_flow_controller;
  import game_pkg::*;

  localparam int DF = 60;
  localparam int DW = 8;
`ifdef LEVEL_TIMER_EN
  localparam int FPS = 2;
  localparam int TL  = 3;
`endif

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          frame_clk = 1'b0;
  logic          start_key = 1'b0;
  logic          fireboy_hazard = 1'b0;
  logic          icegirl_hazard = 1'b0;
  logic          fireboy_at_door = 1'b0;
  logic          icegirl_at_door = 1'b0;
  logic          revive;
  logic          freeze;
  logic [2:0]    game_state;
  logic [DW-1:0] death_count;
  logic [9:0]    play_seconds;

  game_flow_controller #(
    .DEATH_FRAMES (DF),
    .DEATH_W      (DW)
`ifdef LEVEL_TIMER_EN
    ,
    .FRAMES_PER_SEC (FPS),
    .TIME_LIMIT     (TL)
`endif
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .frame_clk       (frame_clk),
    .start_key       (start_key),
    .fireboy_hazard  (fireboy_hazard),
    .icegirl_hazard  (icegirl_hazard),
    .fireboy_at_door (fireboy_at_door),
    .icegirl_at_door (icegirl_at_door),
    .revive          (revive),
    .freeze          (freeze),
    .game_state      (game_state),
    .death_count     (death_count),
    .play_seconds    (play_seconds)
  );

  always #5 Clk = ~Clk;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int n_rev = 0;

  // Reference model: the round rules expressed directly, with a frame countdown.
  game_state_enum m_state = TITLE;
  int m_deaths = 0;
  int m_left = DF;
  int m_secs = 0;
  int m_sub = 0;
  bit fc_d1 = 0, fc_d2 = 0, sk_d1 = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
      if (errs >= 50) begin
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
      end
    end
  endtask

  task automatic model_step();
    bit tick, press, expired;
    tick    = fc_d1 && !fc_d2;
    press   = start_key && !sk_d1;
    expired = 0;
    if (Reset) begin
      m_state = TITLE; m_deaths = 0; m_left = DF; m_secs = 0; m_sub = 0;
      fc_d1 = 0; fc_d2 = 0; sk_d1 = 0;
      return;
    end
    case (m_state)
      TITLE, WIN: if (press) begin m_state = REVIVE; m_deaths = 0; end
      REVIVE: begin m_state = PLAY; m_left = DF; m_secs = 0; m_sub = 0; end
      PLAY: begin
`ifdef LEVEL_TIMER_EN
        expired = (m_secs == TL);
        if (tick) begin
          m_sub++;
          if (m_sub == FPS) begin m_sub = 0; m_secs++; end
        end
`endif
        if (fireboy_hazard || icegirl_hazard || expired) begin
          m_state = DYING;
          if (m_deaths < (1 << DW) - 1) m_deaths++;
        end else if (fireboy_at_door && icegirl_at_door) begin
          m_state = WIN;
        end
      end
      DYING: if (tick) begin
        m_left--;
        if (m_left == 0) m_state = REVIVE;
      end
      default: ;
    endcase
    fc_d2 = fc_d1; fc_d1 = frame_clk; sk_d1 = start_key;
  endtask

  task automatic advance();
    model_step();
    @(posedge Clk);
    @(negedge Clk);
    cyc++;
    if (game_state == REVIVE) n_rev++;
  endtask

  task automatic step();
    advance();
    check("state", int'(game_state), int'(m_state));
    check("revive", int'(revive), int'(m_state == TITLE || m_state == REVIVE));
    check("freeze", int'(freeze), int'(m_state != PLAY));
    check("death_count", int'(death_count), m_deaths);
    check("play_seconds", int'(play_seconds), m_secs);
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1; step(); step();
    frame_clk = 1'b0; step(); step();
  endtask

  typedef struct {
    bit rst, sk, fh, ih, fd, id;
    game_state_enum st;
    bit rv, fz;
    int dc;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int non_play;
    int forced;
    int budget;
    game_state_enum prev;

    vecs[0]  = '{1,0,0,0,0,0, TITLE, 1,1,0};
    vecs[1]  = '{1,1,0,0,0,0, TITLE, 1,1,0};
    vecs[2]  = '{0,0,0,0,0,0, TITLE, 1,1,0};
    vecs[3]  = '{0,1,0,0,0,0, REVIVE,1,1,0};
    vecs[4]  = '{0,1,0,0,0,0, PLAY,  0,0,0};
    vecs[5]  = '{0,1,0,0,0,0, PLAY,  0,0,0};
    vecs[6]  = '{0,1,1,0,0,0, DYING, 0,1,1};
    vecs[7]  = '{0,0,0,0,1,1, DYING, 0,1,1};
    vecs[8]  = '{0,0,1,1,0,0, DYING, 0,1,1};
    vecs[9]  = '{1,0,0,0,0,0, TITLE, 1,1,0};
    vecs[10] = '{0,1,0,0,0,0, REVIVE,1,1,0};
    vecs[11] = '{0,0,0,0,1,0, PLAY,  0,0,0};
    vecs[12] = '{0,0,0,0,1,0, PLAY,  0,0,0};
    vecs[13] = '{0,0,0,0,1,1, WIN,   0,1,0};
    vecs[14] = '{0,0,1,1,0,0, WIN,   0,1,0};
    vecs[15] = '{0,1,0,0,0,0, REVIVE,1,1,0};
    vecs[16] = '{0,0,0,0,0,0, PLAY,  0,0,0};
    vecs[17] = '{0,0,0,1,1,1, DYING, 0,1,1};
    vecs[18] = '{0,1,0,0,0,0, DYING, 0,1,1};
    vecs[19] = '{0,0,0,0,0,0, DYING, 0,1,1};

    for (int i = 0; i < 20; i++) begin
      Reset = vecs[i].rst; start_key = vecs[i].sk;
      fireboy_hazard = vecs[i].fh; icegirl_hazard = vecs[i].ih;
      fireboy_at_door = vecs[i].fd; icegirl_at_door = vecs[i].id;
      advance();
      check("vec_state", int'(game_state), int'(vecs[i].st));
      check("vec_revive", int'(revive), int'(vecs[i].rv));
      check("vec_freeze", int'(freeze), int'(vecs[i].fz));
      check("vec_deaths", int'(death_count), vecs[i].dc);
      check("vec_seconds", int'(play_seconds), 0);
      $display("vec %0d: state=%0d revive=%0d freeze=%0d deaths=%0d", i, game_state, revive, freeze, death_count);
    end
    start_key = 0; fireboy_hazard = 0; icegirl_hazard = 0; fireboy_at_door = 0; icegirl_at_door = 0;

    // Reset, then a start key held for 10 cycles gives one REVIVE cycle.
    Reset = 1; step(); step();
    Reset = 0; step();
    check("reset_deaths", int'(death_count), 0);
    start_key = 1; n_rev = 0;
    repeat (10) step();
    start_key = 0;
    check("held_start_revive_cycles", n_rev, 1);
    check("held_start_play", int'(game_state), int'(PLAY));
    $display("seq start: revive_cycles=%0d", n_rev);

    // One-cycle hazard, then 60 frame rises bring the player back.
    fireboy_hazard = 1; step(); fireboy_hazard = 0;
    check("hazard_dying", int'(game_state), int'(DYING));
    check("hazard_deaths", int'(death_count), 1);
    n_rev = 0;
    repeat (DF) frame_pulse();
    step();
    check("death_revive_cycles", n_rev, 1);
    check("death_back_play", int'(game_state), int'(PLAY));
    $display("seq death: revive_cycles=%0d state=%0d", n_rev, game_state);

    // One player at the door stays in PLAY; both reach WIN; start clears deaths.
    fireboy_at_door = 1; non_play = 0;
    repeat (100) begin step(); if (game_state != PLAY) non_play++; end
    check("one_door_stays_play", non_play, 0);
    icegirl_at_door = 1; step();
    check("both_doors_win", int'(game_state), int'(WIN));
    fireboy_at_door = 0; icegirl_at_door = 0;
    check("win_keeps_deaths", int'(death_count), 1);
    start_key = 1; step(); start_key = 0;
    check("win_start_revive", int'(game_state), int'(REVIVE));
    check("win_start_clears_deaths", int'(death_count), 0);
    step();
    $display("seq win: state=%0d deaths=%0d", game_state, death_count);

    // Hazard together with both doors goes to DYING.
    icegirl_hazard = 1; fireboy_at_door = 1; icegirl_at_door = 1; step();
    icegirl_hazard = 0; fireboy_at_door = 0; icegirl_at_door = 0;
    check("hazard_beats_doors", int'(game_state), int'(DYING));
    check("hazard_beats_doors_deaths", int'(death_count), 1);
    for (int i = 0; i < 80 && m_state != PLAY; i++) frame_pulse();
    check("back_to_play", int'(game_state), int'(PLAY));

    // Six frame ticks in PLAY: the timer build times out, the plain build keeps zero seconds.
    repeat (6) frame_pulse();
    step();
`ifdef LEVEL_TIMER_EN
    check("timeout_dying", int'(game_state), int'(DYING));
    check("timeout_seconds", int'(play_seconds), 3);
    check("timeout_deaths", int'(death_count), 2);
`else
    check("no_timer_play", int'(game_state), int'(PLAY));
    check("no_timer_seconds", int'(play_seconds), 0);
`endif
    $display("seq timer: state=%0d seconds=%0d", game_state, play_seconds);

    // 300 forced deaths saturate the counter; reset in DYING restores reset values.
    fireboy_hazard = 1; forced = 0; budget = 0;
    while (forced < 300 && budget < 45000) begin
      prev = m_state;
      frame_clk = ~frame_clk;
      step();
      if (prev == PLAY && m_state == DYING) forced++;
      budget++;
    end
    check("saturate_in_budget", int'(forced >= 300), 1);
    check("deaths_saturated", int'(death_count), 255);
    for (int i = 0; i < 10 && m_state != DYING; i++) step();
    check("in_dying_before_reset", int'(game_state), int'(DYING));
    Reset = 1; fireboy_hazard = 0; step(); Reset = 0;
    check("reset_state", int'(game_state), int'(TITLE));
    check("reset_revive", int'(revive), 1);
    check("reset_freeze", int'(freeze), 1);
    check("reset_deaths_after_sat", int'(death_count), 0);
    check("reset_seconds", int'(play_seconds), 0);
    $display("seq saturate: forced=%0d", forced);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      Reset           = ($urandom_range(0, 999) == 0);
      start_key       = ($urandom_range(0, 15) == 0);
      fireboy_hazard  = ($urandom_range(0, 99) == 0);
      icegirl_hazard  = ($urandom_range(0, 99) == 0);
      fireboy_at_door = ($urandom_range(0, 3) != 0);
      icegirl_at_door = ($urandom_range(0, 3) != 0);
      frame_clk       = 1'($urandom_range(0, 1));
      step();
    end
    $display("seq random: cycles=%0d", cyc);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
